// File: rtl/pwm_ramp_scheduler.sv
// pwm_ramp_scheduler
//   Soft-start / soft-stop sequencer placed between the SPI command path and
//   the PWM generator. Each channel holds a target and a current duty. Every
//   RAMP_DIV cycles a sweep visits all NCH channels, one per cycle, and moves
//   each current duty toward its target by at most STEP. Within one sweep at
//   most MAX_UP channels may step up, which caps inrush on the shared supply.
//   Down-steps are never limited. The channel that is visited first advances
//   by one after every sweep, so deferred up-steps are shared fairly.
//
// Ports
//   clk50M     system clock
//   rst        synchronous reset, active high
//   cmd_word   [15:12] channel index (15 = broadcast), [11:8] ignored,
//              [7:0] target duty
//   cmd_valid  one-cycle strobe qualifying cmd_word
//   estop      emergency stop, level sensitive; clears like rst but keeps the
//              sweep start pointer
//   duty_out   current duty per channel, channel i in bits [8i+7:8i]
//   busy       high while a sweep is in progress
//   settled    high when every current duty equals its target
//   cmd_err    one-cycle pulse for a command with an unknown channel index
module pwm_ramp_scheduler #(
  parameter int NCH      = 10,
  parameter int RAMP_DIV = 50000,
  parameter int STEP     = 4,
  parameter int MAX_UP   = 2
) (
  input  logic               clk50M,
  input  logic               rst,
  input  logic [15:0]        cmd_word,
  input  logic               cmd_valid,
  input  logic               estop,
  output logic [8*NCH-1:0]   duty_out,
  output logic               busy,
  output logic               settled,
  output logic               cmd_err
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int BW = $clog2(MAX_UP + 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [DW-1:0]   div_reg;
  logic            tick;
  logic [CW-1:0]   k_reg, k_next;
  logic [CW-1:0]   chan_reg, chan_next;
  logic [CW-1:0]   start_ptr_reg, start_ptr_next;
  logic [BW-1:0]   budget_reg, budget_next;
  logic            settled_reg;
  logic            cmd_err_reg;

  logic            clear;
  logic            scan;
  logic            budget_nz;
  logic [3:0]      cmd_idx;
  logic            cmd_bcast;
  logic            cmd_known;
  logic [NCH-1:0]  eq_vec;
  logic [NCH-1:0]  up_take_vec;
  logic            cmd_rsvd_unused;

  assign clear     = rst | estop;
  assign scan      = (state_reg == SCAN);
  assign budget_nz = (budget_reg != '0);
  assign cmd_idx   = cmd_word[15:12];
  assign cmd_bcast = (cmd_idx == 4'hF);
  assign cmd_known = cmd_bcast || (int'(cmd_idx) < NCH);
  assign cmd_rsvd_unused = ^cmd_word[11:8];

  // ---------------------------------------------------------------------
  // Per-channel target / current duty and step arithmetic
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [7:0]        tgt_reg;
    logic [7:0]        cur_reg;
    logic [7:0]        cur_next;
    logic [8:0]        up_sum;
    logic signed [9:0] dn_diff;
    logic              svc;
    logic              wr_hit;

    assign svc    = scan && (chan_reg == CW'(gi));
    assign wr_hit = cmd_valid && (cmd_bcast || (cmd_idx == 4'(gi)));

    // 9-bit sum so the clamp to target happens before any 8-bit overflow;
    // signed difference so the clamp happens before going below zero.
    assign up_sum  = {1'b0, cur_reg} + 9'(STEP);
    assign dn_diff = $signed({2'b00, cur_reg}) - $signed(10'(STEP));

    always_comb begin
      cur_next = cur_reg;
      if (cur_reg < tgt_reg) begin
        if (budget_nz) begin
          cur_next = (up_sum > {1'b0, tgt_reg}) ? tgt_reg : up_sum[7:0];
        end
      end else if (cur_reg > tgt_reg) begin
        cur_next = (dn_diff < $signed({2'b00, tgt_reg})) ? tgt_reg : dn_diff[7:0];
      end
    end

    assign up_take_vec[gi] = svc && budget_nz && (cur_reg < tgt_reg);
    assign eq_vec[gi]      = (cur_reg == tgt_reg);

    // The step reads tgt_reg before this edge, so a write landing on the
    // channel being serviced only takes effect in the next sweep.
    always_ff @(posedge clk50M) begin
      if (clear) begin
        tgt_reg <= '0;
        cur_reg <= '0;
      end else begin
        if (wr_hit) begin
          tgt_reg <= cmd_word[7:0];
        end
        if (svc) begin
          cur_reg <= cur_next;
        end
      end
    end

    assign duty_out[8*gi +: 8] = cur_reg;
  end

  // ---------------------------------------------------------------------
  // Ramp tick divider
  // ---------------------------------------------------------------------
  assign tick = (div_reg == DW'(RAMP_DIV - 1));

  always_ff @(posedge clk50M) begin
    if (clear) begin
      div_reg <= '0;
    end else if (tick) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + DW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    k_next         = k_reg;
    chan_next      = chan_reg;
    budget_next    = budget_reg;
    start_ptr_next = start_ptr_reg;
    case (state_reg)
      IDLE: begin
        // Ticks seen outside IDLE are simply dropped.
        if (tick) begin
          state_next  = SCAN;
          k_next      = '0;
          chan_next   = start_ptr_reg;
          budget_next = BW'(MAX_UP);
        end
      end
      SCAN: begin
        if (|up_take_vec) begin
          budget_next = budget_reg - BW'(1);
        end
        chan_next = (chan_reg == CW'(NCH - 1)) ? '0 : chan_reg + CW'(1);
        k_next    = k_reg + CW'(1);
        if (k_reg == CW'(NCH - 1)) begin
          state_next     = IDLE;
          start_ptr_next = (start_ptr_reg == CW'(NCH - 1)) ? '0
                                                           : start_ptr_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      state_reg     <= IDLE;
      k_reg         <= '0;
      chan_reg      <= '0;
      budget_reg    <= '0;
      start_ptr_reg <= '0;
    end else if (estop) begin
      // Emergency stop aborts the sweep but keeps the rotation position.
      state_reg     <= IDLE;
      k_reg         <= '0;
      chan_reg      <= '0;
      budget_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      k_reg         <= k_next;
      chan_reg      <= chan_next;
      budget_reg    <= budget_next;
      start_ptr_reg <= start_ptr_next;
    end
  end

  // ---------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk50M) begin
    if (clear) begin
      settled_reg <= 1'b1;
      cmd_err_reg <= 1'b0;
    end else begin
      settled_reg <= &eq_vec;
      cmd_err_reg <= cmd_valid && !cmd_known;
    end
  end

  assign busy    = scan;
  assign settled = settled_reg;
  assign cmd_err = cmd_err_reg;

endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// tb_pwm_ramp_scheduler
//   Directed bench for pwm_ramp_scheduler (NCH=10, RAMP_DIV=16, STEP=4,
//   MAX_UP=2). The stimulus process pushes the hand-derived duty vector and
//   busy length expected at the end of each sweep; a monitor process pops
//   and compares whenever busy falls. Static outputs (reset state, settled,
//   cmd_err) are compared directly by the stimulus.
module tb_pwm_ramp_scheduler;

  localparam int NCH      = 10;
  localparam int RAMP_DIV = 16;
  localparam int STEP     = 4;
  localparam int MAX_UP   = 2;
  localparam int VW       = 8 * NCH;

  logic            clk50M = 1'b0;
  logic            rst;
  logic [15:0]     cmd_word;
  logic            cmd_valid;
  logic            estop;
  logic [VW-1:0]   duty_out;
  logic            busy;
  logic            settled;
  logic            cmd_err;

  always #5 clk50M = ~clk50M;

  pwm_ramp_scheduler #(
    .NCH      (NCH),
    .RAMP_DIV (RAMP_DIV),
    .STEP     (STEP),
    .MAX_UP   (MAX_UP)
  ) dut (
    .clk50M    (clk50M),
    .rst       (rst),
    .cmd_word  (cmd_word),
    .cmd_valid (cmd_valid),
    .estop     (estop),
    .duty_out  (duty_out),
    .busy      (busy),
    .settled   (settled),
    .cmd_err   (cmd_err)
  );

  typedef struct {
    logic [VW-1:0] duty;
    int            len;
  } sweep_exp_t;

  sweep_exp_t sweep_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         sweep_no = 0;
  logic [7:0] exp_duty [NCH];

  function automatic logic [VW-1:0] pack_exp();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) v[8*i +: 8] = exp_duty[i];
    return v;
  endfunction

  task automatic check(input string name, input logic [VW-1:0] act,
                       input logic [VW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired waiting for busy", name);
  endtask

  // ---------------------------------------------------------------------
  // Monitor: one comparison set per completed (or aborted) sweep
  // ---------------------------------------------------------------------
  initial begin : monitor
    int         run_len;
    sweep_exp_t e;
    run_len = 0;
    forever begin
      @(negedge clk50M);
      if (busy === 1'b1) begin
        run_len++;
      end else if (run_len > 0) begin
        sweep_no++;
        if (sweep_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_sweep: sweep %0d got duty %h, required no sweep",
                   sweep_no, duty_out);
        end else begin
          e = sweep_q.pop_front();
          $display("sweep %0d: duty=%h busy_cycles=%0d", sweep_no, duty_out, run_len);
          check("sweep_duty", duty_out, e.duty);
          check("sweep_busy_len", VW'(run_len), VW'(e.len));
        end
        run_len = 0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk50M);
    @(negedge clk50M);
    rst = 1'b0;
    for (int i = 0; i < NCH; i++) exp_duty[i] = 8'h00;
  endtask

  task automatic cmd(input logic [15:0] w);
    cmd_word  = w;
    cmd_valid = 1'b1;
    @(negedge clk50M);
    cmd_valid = 1'b0;
    cmd_word  = 16'h0000;
  endtask

  task automatic wait_busy(input logic level, input string name);
    int t;
    t = 0;
    while (busy !== level && t < 40) begin
      @(negedge clk50M);
      t++;
    end
    if (busy !== level) timeout(name);
  endtask

  task automatic expect_sweep(input int len);
    sweep_q.push_back('{duty: pack_exp(), len: len});
    wait_busy(1'b1, "sweep_start");
    wait_busy(1'b0, "sweep_end");
  endtask

  // Broadcast ramp from 0 to 0x20 with MAX_UP=2: in sweep i the start
  // channel (i mod NCH) and the next one step up, so after sweep j channel c
  // has stepped once for every i<=j with i mod NCH == c or (i+1) mod NCH == c.
  task automatic ramp40();
    for (int j = 0; j < 40; j++) begin
      for (int c = 0; c < NCH; c++) begin
        int n;
        n = 0;
        for (int i = 0; i <= j; i++) begin
          if ((i % NCH) == c || ((i + 1) % NCH) == c) n++;
        end
        exp_duty[c] = 8'(4 * n);
      end
      expect_sweep(10);
      if (j == 38) check("ramp_not_settled_39", VW'(settled), VW'(0));
    end
    check("ramp_settled_40", VW'(settled), VW'(1));
  endtask

  // ---------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------
  initial begin : stimulus
    rst       = 1'b1;
    cmd_word  = 16'h0000;
    cmd_valid = 1'b0;
    estop     = 1'b0;

    // Reset state
    do_reset();
    check("reset_duty", duty_out, '0);
    check("reset_busy", VW'(busy), VW'(0));
    check("reset_settled", VW'(settled), VW'(1));
    check("reset_cmd_err", VW'(cmd_err), VW'(0));

    // Single channel ramp 0 -> 10
    cmd(16'h300A);
    check("s2_settled_lag", VW'(settled), VW'(1));
    @(negedge clk50M);
    check("s2_settled_drop", VW'(settled), VW'(0));
    exp_duty[3] = 8'd4;
    expect_sweep(10);
    check("s2_settled_sw1", VW'(settled), VW'(0));
    exp_duty[3] = 8'd8;
    expect_sweep(10);
    check("s2_settled_sw2", VW'(settled), VW'(0));
    exp_duty[3] = 8'd10;
    expect_sweep(10);
    check("s2_settled_sw3", VW'(settled), VW'(1));

    // Broadcast ramp with up-step limit and rotation
    do_reset();
    cmd(16'hF020);
    ramp40();

    // Concurrent down-steps (all channels at 0x20 here)
    cmd(16'h300A);
    cmd(16'h1000);
    cmd(16'h2000);
    cmd(16'h4000);
    cmd(16'h5000);
    for (int n = 1; n <= 6; n++) begin
      exp_duty[3] = (32 - 4 * n > 10) ? 8'(32 - 4 * n) : 8'd10;
      exp_duty[1] = 8'(32 - 4 * n);
      exp_duty[2] = 8'(32 - 4 * n);
      exp_duty[4] = 8'(32 - 4 * n);
      exp_duty[5] = 8'(32 - 4 * n);
      expect_sweep(10);
    end
    cmd(16'h3000);
    exp_duty[3] = 8'd6;
    exp_duty[1] = 8'd4; exp_duty[2] = 8'd4; exp_duty[4] = 8'd4; exp_duty[5] = 8'd4;
    expect_sweep(10);
    exp_duty[3] = 8'd2;
    exp_duty[1] = 8'd0; exp_duty[2] = 8'd0; exp_duty[4] = 8'd0; exp_duty[5] = 8'd0;
    expect_sweep(10);
    exp_duty[3] = 8'd0;
    expect_sweep(10);
    check("s4_settled", VW'(settled), VW'(1));

    // Rejected commands
    cmd(16'hC055);
    check("s5_err_pulse", VW'(cmd_err), VW'(1));
    @(negedge clk50M);
    check("s5_err_one_cycle", VW'(cmd_err), VW'(0));
    cmd(16'hA0FF);
    check("s5_err_idx_nch", VW'(cmd_err), VW'(1));
    cmd(16'h3000);
    check("s5_no_err_valid", VW'(cmd_err), VW'(0));
    check("s5_settled", VW'(settled), VW'(1));
    expect_sweep(10);

    // Emergency stop mid-sweep
    do_reset();
    cmd(16'hF020);
    ramp40();
    for (int i = 0; i < NCH; i++) exp_duty[i] = 8'h00;
    sweep_q.push_back('{duty: pack_exp(), len: 3});
    wait_busy(1'b1, "estop_sweep_start");
    @(negedge clk50M);
    @(negedge clk50M);
    estop = 1'b1;
    @(negedge clk50M);
    check("s6_duty_cleared", duty_out, '0);
    check("s6_busy", VW'(busy), VW'(0));
    check("s6_settled", VW'(settled), VW'(1));
    cmd(16'h3040);
    cmd(16'hB000);
    check("s6_no_err", VW'(cmd_err), VW'(0));
    estop = 1'b0;
    expect_sweep(10);
    expect_sweep(10);
    check("s6_settled_after", VW'(settled), VW'(1));

    @(negedge clk50M);
    check("queue_drained", VW'(sweep_q.size()), VW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
